// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of pipeline-status inputs and PC/pipeline-control
//                outputs shared between the datapath and pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic [15:0] pc;
    logic        ex_branch_taken;
    logic [15:0] ex_target;
    logic        idex_mem_read;
    logic [3:0]  idex_rd;
    logic [3:0]  ifid_rs;
    logic [3:0]  ifid_rt;
    logic        id_halt;
    logic        resume;

    logic [15:0] next_pc;
    logic        pc_stop;
    logic        pc_halt;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [15:0] stall_count;

    // Datapath side: supplies pipeline status, consumes control
    modport master (
        output pc, ex_branch_taken, ex_target, idex_mem_read, idex_rd,
               ifid_rs, ifid_rt, id_halt, resume,
        input  next_pc, pc_stop, pc_halt, ifid_write, ifid_flush,
               idex_flush, halted, stall_count
    );

    // Sequencer side
    modport slave (
        input  pc, ex_branch_taken, ex_target, idex_mem_read, idex_rd,
               ifid_rs, ifid_rt, id_halt, resume,
        output next_pc, pc_stop, pc_halt, ifid_write, ifid_flush,
               idex_flush, halted, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC selection, load-use stall, branch flush and a
//                RUN -> DRAIN -> HALTED halt sequence with stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pc_sequencer_if.slave seq_if
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] C_DRAIN_LOAD = 3'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_count_q;

    logic        w_hazard;
    logic [15:0] w_next_pc;
    logic        w_pc_stop;
    logic        w_pc_halt;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic        w_idex_flush;

    assign w_hazard = seq_if.idex_mem_read && (seq_if.idex_rd != 4'd0) &&
                      ((seq_if.idex_rd == seq_if.ifid_rs) ||
                       (seq_if.idex_rd == seq_if.ifid_rt));

    // State and drain-counter registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and control outputs; reset forces a safe bubble-filled pipe
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        w_next_pc    = seq_if.pc + 16'd2;
        w_pc_stop    = 1'b0;
        w_pc_halt    = 1'b0;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (!rst_n) begin
            state_d      = ST_RUN;
            drain_cnt_d  = 3'd0;
            w_next_pc    = RESET_VECTOR;
            w_pc_stop    = 1'b1;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (seq_if.ex_branch_taken) begin
                        // Younger instructions are wrong-path: halt/hazard ignored
                        w_next_pc    = seq_if.ex_target;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_hazard) begin
                        // A coincident halt waits here until the load retires
                        w_next_pc    = seq_if.pc;
                        w_pc_stop    = 1'b1;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                    end else if (seq_if.id_halt) begin
                        w_next_pc    = seq_if.pc;
                        w_pc_halt    = 1'b1;
                        w_ifid_flush = 1'b1;
                        drain_cnt_d  = C_DRAIN_LOAD;
                        state_d      = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    w_next_pc    = seq_if.pc;
                    w_pc_halt    = 1'b1;
                    w_ifid_write = 1'b0;
                    w_ifid_flush = 1'b1;
                    drain_cnt_d  = drain_cnt_q - 3'd1;
                    if (drain_cnt_q <= 3'd1) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    w_next_pc    = seq_if.pc;
                    w_pc_halt    = 1'b1;
                    w_ifid_write = 1'b0;
                    w_ifid_flush = 1'b1;
                    if (seq_if.resume) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 16'd0;
        end else if ((w_pc_stop || w_pc_halt) && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign seq_if.next_pc     = w_next_pc;
    assign seq_if.pc_stop     = w_pc_stop;
    assign seq_if.pc_halt     = w_pc_halt;
    assign seq_if.ifid_write  = w_ifid_write;
    assign seq_if.ifid_flush  = w_ifid_flush;
    assign seq_if.idex_flush  = w_idex_flush;
    assign seq_if.halted      = (state_q == ST_HALTED);
    assign seq_if.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, value driven on next_pc while reset is held.
REQ-002 Parameter DRAIN_CYCLES, default 3, number of cycles the halt instruction needs to retire after leaving ID (range 1..7).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-005 pc  input  16  current PC register value.
REQ-006 ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle.
REQ-007 ex_target  input  16  branch/jump target from EX.
REQ-008 idex_mem_read  input  1  instruction in EX is a load.
REQ-009 idex_rd  input  4  destination register of the instruction in EX.
REQ-010 ifid_rs, ifid_rt  input  4 each  source registers of the instruction in ID.
REQ-011 id_halt  input  1  instruction in ID decodes as HALT.
REQ-012 resume  input  1  single-cycle pulse to restart from HALTED.
REQ-013 next_pc  output  16  value the PC loads this cycle.
REQ-014 pc_stop  output  1  PC holds for a hazard stall.
REQ-015 pc_halt  output  1  PC holds for a halt.
REQ-016 ifid_write  output  1  IF/ID register load enable.
REQ-017 ifid_flush, idex_flush  output  1 each  insert bubble into IF/ID or ID/EX.
REQ-018 halted  output  1  high while in state HALTED.
REQ-019 stall_count  output  16  cycles in which pc_stop or pc_halt was high.

Function
REQ-020 The FSM SHALL have states RUN, DRAIN and HALTED, with RUN as the reset state.
REQ-021 Defaults in RUN SHALL be: next_pc = pc + 2 (16-bit, wraps FFFE->0000); pc_stop = pc_halt = 0; ifid_write = 1; both flushes = 0.
REQ-022 Load-use hazard SHALL be defined as idex_mem_read & (idex_rd != 0) & (idex_rd == ifid_rs | idex_rd == ifid_rt).
REQ-023 Priority in RUN SHALL be: branch > load-use > halt.
REQ-024 On branch in RUN, the same cycle SHALL drive next_pc = ex_target, ifid_flush = 1 and idex_flush = 1; the FSM SHALL stay in RUN, and id_halt and the hazard are ignored as wrong-path.
REQ-025 On load-use without branch, the same cycle SHALL drive next_pc = pc, pc_stop = 1, ifid_write = 0 and idex_flush = 1, with no state change.
REQ-026 On id_halt with no branch and no hazard, the same cycle SHALL drive next_pc = pc, pc_halt = 1 and ifid_flush = 1, load the drain counter with DRAIN_CYCLES, and go to DRAIN.
REQ-027 A halt coincident with load-use SHALL be stalled first and take effect in a later cycle once the hazard clears.
REQ-028 In DRAIN, the block SHALL drive next_pc = pc, pc_halt = 1, ifid_write = 0 and ifid_flush = 1, and decrement the counter each cycle.
REQ-029 In DRAIN, ex_branch_taken, the hazard and resume SHALL be ignored, and the FSM SHALL go to HALTED on the cycle the counter reads 1.
REQ-030 In HALTED, the block SHALL drive pc_halt = 1, ifid_write = 0, ifid_flush = 1 and halted = 1.
REQ-031 A resume in HALTED SHALL go to RUN next cycle, with fetch continuing from the held pc (halt address + 2).
REQ-032 resume SHALL be ignored in RUN and DRAIN.
REQ-033 stall_count SHALL increment on each posedge where pc_stop | pc_halt, saturate at 16'hFFFF, and have no wrap.

Reset
REQ-034 While rst = 0 the block SHALL force: state RUN, drain counter 0, stall_count 0, next_pc = RESET_VECTOR, pc_stop = 1, pc_halt = 0, ifid_write = 0, both flushes = 1, halted = 0.
REQ-035 Reset asserted mid-DRAIN or in HALTED SHALL abandon the halt, and the first cycle after release SHALL behave as RUN.
REQ-036 Reset SHALL dominate resume and all other inputs.

Verification
REQ-037 Scenario: release reset with pc = 0000 and no hazards -> next_pc = 0002 and stall_count stays 0.
REQ-038 Scenario: idex_mem_read = 1, idex_rd = 3, ifid_rs = 3 for one cycle -> pc_stop = 1, ifid_write = 0, idex_flush = 1, next_pc = pc, stall_count +1; the same with idex_rd = 0 -> no stall.
REQ-039 Scenario: ex_branch_taken = 1, ex_target = 0x0040, id_halt = 1 -> next_pc = 0x0040, both flushes = 1, no halt, FSM remains RUN.
REQ-040 Scenario: id_halt at pc = 0x0010 -> pc_halt high for 1 + 3 cycles, halted rises on the 4th posedge, next_pc holds 0x0010; resume -> next_pc = 0x0012 next cycle.
REQ-041 Scenario: pc = FFFE in RUN -> next_pc = 0000.
REQ-042 Scenario: stall_count preloaded near saturation via a long HALTED period -> holds at FFFF; rst = 0 during DRAIN -> halted = 0 and stall_count = 0 immediately, without waiting for a clock edge.
